// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver. Synchronizes rx, samples each bit mid-period
// and hands the byte to a one-entry valid/ready holding register.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 en,
  input  logic [15:0]          baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_N-1:0]    sync_q;
  logic                 rx_prev_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 rx_s, fall_s, tick_s;
  logic [15:0]          per_s, half_s;

  assign rx_s   = sync_q[SYNC_N-1];
  assign fall_s = rx_prev_q & ~rx_s;
  // The counter is loaded with N and ticks when it reaches 1, i.e. N cycles later.
  assign tick_s = (cnt_q == 16'd1);
  assign per_s  = (baud_div < 16'd2) ? 16'd2 : baud_div;
  assign half_s = per_s >> 1;

  // rx synchronizer plus previous-sample flop for falling-edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q    <= {SYNC_N{1'b1}};
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_N-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = fall_s ? S_START : S_IDLE;
        S_START: state_d = tick_s ? (rx_s ? S_IDLE : S_DATA) : S_START;
        S_DATA:  state_d = (tick_s && (idx_q == LAST_IDX)) ? S_STOP : S_DATA;
        S_STOP:  state_d = tick_s ? S_IDLE : S_STOP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM output / datapath next-state logic
  always_comb begin
    cnt_d   = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : 16'd0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = (valid_q && ready) ? 1'b0 : valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    if (!en) begin
      cnt_d = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall_s) cnt_d = half_s;
          else        cnt_d = 16'd0;
        end
        S_START: begin
          if (tick_s && !rx_s) begin
            cnt_d = per_s;
            idx_d = '0;
          end else begin
            idx_d = idx_q;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            cnt_d   = per_s;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            shreg_d = shreg_q;
          end
        end
        S_STOP: begin
          if (tick_s && rx_s) begin
            // A full holding register is only replaced if it drains this cycle.
            if (!valid_q || ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else if (tick_s) begin
            fe_d = 1'b1;
          end else begin
            fe_d = 1'b0;
          end
        end
        default: cnt_d = 16'd0;
      endcase
    end
  end

  // datapath and holding register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames on rx; expected bytes go into a scoreboard
// queue that a monitor pops whenever a new byte is presented.
module tb_uart_rx_core;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        en;
  logic [15:0] baud_div;
  logic        rx;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int fe0, ov0;

  typedef struct {
    logic [7:0] b;
    int         start;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .baud_div(baud_div), .rx(rx),
    .data(data), .valid(valid), .ready(ready), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive one frame starting at the current negedge; p cycles per bit, one idle bit after.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
    rx = 1'b0;
    repeat (p) @(negedge HCLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge HCLK);
    end
    rx = stop;
    repeat (p) @(negedge HCLK);
    rx = 1'b1;
    repeat (p) @(negedge HCLK);
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge HCLK);
    ready = 1'b0;
  endtask

  // Monitor: counts flag pulses and checks each newly presented byte.
  initial begin : monitor
    logic       v_prev;
    logic [7:0] d_prev;
    exp_t       e;
    v_prev = 1'b0;
    d_prev = 8'h00;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        v_prev = 1'b0;
        d_prev = 8'h00;
      end else begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1)   ov_cnt++;
        if (valid === 1'b1 && (!v_prev || data !== d_prev)) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got data %0h expected no output", data);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", {24'd0, data}, {24'd0, e.b});
            chk_range("rx_latency", cyc - e.start, e.lat - 2, e.lat + 2);
          end
        end
        v_prev = valid;
        d_prev = data;
      end
    end
  end

  initial begin
    HRESETn  = 1'b0;
    en       = 1'b0;
    rx       = 1'b1;
    ready    = 1'b0;
    baud_div = 16'd16;
    repeat (3) @(negedge HCLK);
    chk("rst_data", {24'd0, data}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_flags", {30'd0, frame_err, overrun}, 32'h0);
    HRESETn = 1'b1;
    en      = 1'b1;
    repeat (4) @(negedge HCLK);

    // nominal 0xA5, ready low
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back('{8'hA5, cyc, 155});
    send_frame(8'hA5, 1'b1, 16);
    chk("nom_valid", {31'd0, valid}, 32'h1);
    chk("nom_data", {24'd0, data}, 32'hA5);
    chk("nom_fe", fe_cnt - fe0, 32'd0);
    chk("nom_ov", ov_cnt - ov0, 32'd0);

    // reset in the middle of a frame
    rx = 1'b0;
    repeat (40) @(negedge HCLK);
    chk("midrst_busy_before", {31'd0, busy}, 32'h1);
    HRESETn = 1'b0;
    #1;
    chk("midrst_data", {24'd0, data}, 32'h0);
    chk("midrst_valid", {31'd0, valid}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);

    // clean frame after reset, consumer ready
    ready = 1'b1;
    exp_q.push_back('{8'h3E, cyc, 155});
    send_frame(8'h3E, 1'b1, 16);
    chk("postrst_drained", {31'd0, valid}, 32'h0);
    ready = 1'b0;

    // 4-cycle glitch
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    repeat (4) @(negedge HCLK);
    rx = 1'b1;
    chk("glitch_busy", {31'd0, busy}, 32'h1);
    repeat (16) @(negedge HCLK);
    chk("glitch_idle", {31'd0, busy}, 32'h0);
    chk("glitch_valid", {31'd0, valid}, 32'h0);
    chk("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // framing error then a good frame
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 16);
    chk("frame_fe", fe_cnt - fe0, 32'd1);
    chk("frame_valid", {31'd0, valid}, 32'h0);
    exp_q.push_back('{8'h81, cyc, 155});
    send_frame(8'h81, 1'b1, 16);
    chk("frame_next_data", {24'd0, data}, 32'h81);
    pulse_ready();
    chk("frame_drain", {31'd0, valid}, 32'h0);

    // overrun: second byte lost
    ov0 = ov_cnt;
    exp_q.push_back('{8'h11, cyc, 155});
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    chk("ovr_pulse", ov_cnt - ov0, 32'd1);
    chk("ovr_data", {24'd0, data}, 32'h11);
    chk("ovr_valid", {31'd0, valid}, 32'h1);
    pulse_ready();
    chk("ovr_drain", {31'd0, valid}, 32'h0);

    // back-to-back: ready high exactly in the stop-sample cycle
    ov0 = ov_cnt;
    exp_q.push_back('{8'h11, cyc, 155});
    send_frame(8'h11, 1'b1, 16);
    exp_q.push_back('{8'h22, cyc, 155});
    fork
      send_frame(8'h22, 1'b1, 16);
      begin
        repeat (154) @(negedge HCLK);
        ready = 1'b1;
        @(negedge HCLK);
        ready = 1'b0;
      end
    join
    chk("b2b_data", {24'd0, data}, 32'h22);
    chk("b2b_valid", {31'd0, valid}, 32'h1);
    chk("b2b_ov", ov_cnt - ov0, 32'd0);
    pulse_ready();
    chk("b2b_drain", {31'd0, valid}, 32'h0);

    // enable dropped mid-frame
    fork
      send_frame(8'h5A, 1'b1, 16);
      begin
        repeat (50) @(negedge HCLK);
        chk("endrop_busy_before", {31'd0, busy}, 32'h1);
        en = 1'b0;
        @(negedge HCLK);
        chk("endrop_busy", {31'd0, busy}, 32'h0);
      end
    join
    en = 1'b1;
    repeat (20) @(negedge HCLK);
    chk("endrop_valid", {31'd0, valid}, 32'h0);

    // baud_div below 2 clamps to a 2-cycle bit
    baud_div = 16'd0;
    ready    = 1'b1;
    exp_q.push_back('{8'hC3, cyc, 22});
    send_frame(8'hC3, 1'b1, 2);
    repeat (4) @(negedge HCLK);
    chk("clamp_drained", {31'd0, valid}, 32'h0);
    ready    = 1'b0;
    baud_div = 16'd16;

    repeat (20) @(negedge HCLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("total_fe", fe_cnt, 32'd1);
    chk("total_ov", ov_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
